// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer for the single-issue core's fetch path: runs the
// imem request/ready and decode valid/ack handshakes, redirects, stalls, halts and fetch timeout.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc_out,
  output logic        fetch_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    HALTED = 3'd3
  } state_t;

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [31:0]      tgt_w;
  logic [31:0]      pc_inc_w;

  assign tgt_w    = redirect_target & ALIGN_MASK;
  assign pc_inc_w = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) pc_d = tgt_w;
        if (halt)        state_d = HALTED;
        else if (!stall) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          cnt_d = '0;
          // A redirect seen during the request wins over the returning word.
          if (redirect) begin
            pc_d   = tgt_w;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            state_d = ISSUE;
          end
        end else begin
          if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt_w;
          end
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (redirect) begin
          pc_d    = tgt_w;
          state_d = stall ? IDLE : FETCH;
        end else if (instr_ack) begin
          pc_d    = pc_inc_w;
          state_d = halt ? HALTED : (stall ? IDLE : FETCH);
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Pending target is only meaningful while pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == ISSUE);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign fetch_err   = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each driven cycle queues the hand-derived
// expected outputs, and a negedge monitor pops and compares them after the edge.
module tb_pc_fetch_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_ISSUE = 3'd2, S_HALT = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        halt;
  logic [31:0] pc_out;
  logic        fetch_err;
  logic [2:0]  state;

  typedef struct {
    int          due;
    logic [2:0]  st;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   cyc_n  = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ack       (instr_ack),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .stall           (stall),
    .halt            (halt),
    .pc_out          (pc_out),
    .fetch_err       (fetch_err),
    .state           (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
      exp_t e;
      e = sbq.pop_front();
      chk_vec("state",       32'(state),       32'(e.st));
      chk_vec("pc_out",      pc_out,           e.pc);
      chk_vec("imem_addr",   imem_addr,        e.pc);
      chk_vec("imem_req",    32'(imem_req),    32'(e.st == S_FETCH));
      chk_vec("instr_valid", 32'(instr_valid), 32'(e.st == S_ISSUE));
      chk_vec("instr",       instr,            e.ins);
      chk_vec("fetch_err",   32'(fetch_err),   32'(e.err));
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic r, input logic rdy, input logic [31:0] rd, input logic ack,
                      input logic rdr, input logic [31:0] tg, input logic stl, input logic hlt,
                      input logic [2:0] es, input logic [31:0] epc, input logic [31:0] ei,
                      input logic ee);
    exp_t e;
    reset = r; imem_ready = rdy; imem_rdata = rd; instr_ack = ack;
    redirect = rdr; redirect_target = tg; stall = stl; halt = hlt;
    e.due = cyc_n + 1; e.st = es; e.pc = epc; e.ins = ei; e.err = ee;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    redirect = 1'b0; redirect_target = '0; stall = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then straight-line flow 0,4,8,C
    step(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);
    step(1'b0,1'b1,32'hFFFF_FFFF,1'b1,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1,1'b1,32'hA000_0000 + 32'(4*i),1'b0,1'b0,32'h0,1'b0,1'b0,
           S_ISSUE, 32'(4*i), 32'hA000_0000 + 32'(4*i), 1'b0);
      step(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0,
           S_FETCH, 32'(4*i+4), 32'hA000_0000 + 32'(4*i), 1'b0);
    end

    // Wait states: ready on the 4th request cycle, ack on the 3rd issue cycle
    for (int i = 0; i < 3; i++)
      step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h10, 32'hA000_000C, 1'b0);
    step(1'b1,1'b1,32'hB000_0010,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'h10, 32'hB000_0010, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'h10, 32'hB000_0010, 1'b0);
    step(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h14, 32'hB000_0010, 1'b0);

    // Redirect to 0x103 while waiting: pc holds, returned word dropped, refetch at 0x100
    step(1'b1,1'b0,32'h0,1'b0,1'b1,32'h103,1'b0,1'b0, S_FETCH, 32'h14, 32'hB000_0010, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h14, 32'hB000_0010, 1'b0);
    step(1'b1,1'b1,32'hDEAD_BEEF,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h100, 32'hB000_0010, 1'b0);
    step(1'b1,1'b1,32'hC000_0100,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'h100, 32'hC000_0100, 1'b0);
    step(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h104, 32'hC000_0100, 1'b0);

    // Redirect in the same cycle as ready
    step(1'b1,1'b1,32'hDEAD_0000,1'b0,1'b1,32'h300,1'b0,1'b0, S_FETCH, 32'h300, 32'hC000_0100, 1'b0);
    step(1'b1,1'b1,32'hE000_0300,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'h300, 32'hE000_0300, 1'b0);

    // Redirect beats ack and halt in ISSUE
    step(1'b1,1'b0,32'h0,1'b1,1'b1,32'h200,1'b0,1'b1, S_FETCH, 32'h200, 32'hE000_0300, 1'b0);
    step(1'b1,1'b1,32'hF000_0200,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'h200, 32'hF000_0200, 1'b0);

    // Stall at ISSUE exit parks in IDLE
    step(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1,1'b0, S_IDLE, 32'h204, 32'hF000_0200, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,1'b0, S_IDLE, 32'h204, 32'hF000_0200, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h204, 32'hF000_0200, 1'b0);

    // Timeout: 16 request cycles without ready
    for (int i = 0; i < 15; i++)
      step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h204, 32'hF000_0200, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_HALT, 32'h204, 32'hF000_0200, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1,1'b1,$urandom,1'b1,1'b1,32'h500,1'b0,1'b0, S_HALT, 32'h204, 32'hF000_0200, 1'b1);
    step(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);

    // Wrap and halt from 0xFFFF_FFFC
    step(1'b1,1'b0,32'h0,1'b0,1'b1,32'hFFFF_FFFF,1'b1,1'b0, S_IDLE, 32'hFFFF_FFFC, 32'h0, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'hFFFF_FFFC, 32'h0, 1'b0);
    step(1'b1,1'b1,32'h1234_5678,1'b0,1'b0,32'h0,1'b0,1'b0, S_ISSUE, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
    step(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,1'b1, S_HALT, 32'h0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1,1'b1,32'h5555_AAAA,1'b1,1'b0,32'h0,1'b0,1'b0, S_HALT, 32'h0, 32'h1234_5678, 1'b0);

    // Halt straight from IDLE, then reset abandoning an outstanding request
    step(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b1, S_HALT, 32'h0, 32'h0, 1'b0);
    step(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);
    step(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_FETCH, 32'h0, 32'h0, 1'b0);
    step(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,1'b0, S_IDLE, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_vec("sb_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Sequencer for the program counter and instruction-fetch path of the single-issue RISC-V core. Owns the PC register and decides when it advances, redirects, stalls or halts. Runs a request/ready handshake with instruction memory and a valid/ack handshake with decode, so the PC advances only once per instruction actually accepted downstream. Also bounds memory latency with a fetch timeout.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TIMEOUT, 16, max cycles FETCH waits for imem_ready before error (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc_out
- imem_ready  in  1  memory returns data this cycle (valid only while imem_req=1)
- imem_rdata  in  32  instruction word, valid with imem_ready
- instr  out  32  captured instruction for decode
- instr_valid  out  1  instr is valid and held for decode
- instr_ack  in  1  decode accepts instr this cycle
- redirect  in  1  branch/jump/trap taken; load redirect_target
- redirect_target  in  32  new PC; bits [1:0] forced to 0
- stall  in  1  hold off new fetches
- halt  in  1  stop fetching after current instruction
- pc_out  out  32  current PC
- fetch_err  out  1  sticky; memory timeout occurred
- state  out  3  FSM state: IDLE=0, FETCH=1, ISSUE=2, HALTED=3

## Operation
- Reset (reset=0 at clk edge): pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, fetch_err=0, wait counter=0, redirect pending=0.
- imem_req=1 exactly when state=FETCH. instr_valid=1 exactly when state=ISSUE. imem_addr=pc_out always.
- IDLE:
  - redirect: pc←target.
  - halt: →HALTED.
  - else !stall: →FETCH.
  - else stay in IDLE.
- FETCH:
  - Wait counter increments each cycle without imem_ready.
  - imem_ready with no pending redirect: instr←imem_rdata, counter←0, →ISSUE.
  - imem_ready with pending redirect (set by redirect seen earlier in this FETCH): data discarded, pc←pending target, pending←0, counter←0, stay FETCH. imem_addr changes on the next cycle.
  - redirect in the same cycle as imem_ready: data discarded, pc←redirect_target, stay FETCH.
  - redirect without imem_ready: pending←1, pending target←redirect_target. A later redirect overwrites it. pc does not change while the request is outstanding.
  - Counter reaches TIMEOUT−1 with no imem_ready: fetch_err←1, →HALTED.
- ISSUE (priority: redirect > halt > ack):
  - redirect: pc←target, →FETCH, or →IDLE if stall. Current instr is dropped even if instr_ack=1.
  - instr_ack & halt: pc←pc+4, →HALTED.
  - instr_ack: pc←pc+4, →FETCH if !stall else IDLE.
  - No ack: hold instr and pc.
- HALTED: all outputs hold; imem_req=0. Exits only through reset.
- PC arithmetic: 32-bit modulo, so 0xFFFF_FFFC+4 = 0x0000_0000. pc[1:0] is always 00.

## Timing
- All state and outputs are registered. Changes appear one cycle after the sampling edge.
- Best-case throughput (imem_ready on the first FETCH cycle, ack on the first ISSUE cycle): one instruction per 2 cycles.
- From reset deassertion with stall=0: IDLE on the first cycle, imem_req=1 on the second.
- Redirect in ISSUE: imem_addr=target on the following cycle.
- stall affects only the FETCH/IDLE choice at IDLE and at ISSUE exit. It never aborts an outstanding FETCH or an instr awaiting ack.
- Reset mid-FETCH: request is dropped at once (imem_req=0 the next cycle). Memory must tolerate an abandoned request.

## Test plan
- Straight-line flow: RESET_PC=0, imem_ready every FETCH cycle, ack every ISSUE cycle -> imem_addr sequence 0,4,8,C; instr_valid every other cycle; pc_out=0x10 after 4 acks.
- Wait states and backpressure: imem_ready after 3 cycles, ack after 2 -> imem_req high 4 cycles, addr held stable; instr held stable 3 cycles; pc advances once per ack.
- Redirect during FETCH: redirect to 0x103 while waiting -> pc unchanged until ready; returned data dropped (instr_valid stays 0); next request to 0x100.
- Redirect vs ack in ISSUE: redirect=1 to 0x200 with instr_ack=1 and halt=1 -> pc=0x200, state FETCH, no halt.
- Timeout: TIMEOUT=16, imem_ready never asserted -> fetch_err=1 and state=HALTED after 16 FETCH cycles; stays there until reset=0, which then gives pc=RESET_PC and fetch_err=0.
- Wrap and halt: pc=0xFFFF_FFFC, ack with halt=1 -> pc=0x0, state HALTED, imem_req=0 thereafter.
